// File: rtl/fp16_pkg.sv
// Shared IEEE half-precision types and constants for the fp16 datapath.
package fp16_pkg;

    localparam int unsigned FLOAT_LEN = 16;
    localparam int unsigned EXP_LEN   = 5;
    localparam int unsigned MANT_LEN  = 10;

    typedef logic [FLOAT_LEN-1:0] fp16_t;

    typedef struct packed {
        logic                sign;
        logic [EXP_LEN-1:0]  exp;
        logic [MANT_LEN-1:0] mant;
    } fp16_fields_t;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_ONE  = 16'h3C00;
    localparam fp16_t FP16_PINF = 16'h7C00;
    localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/float16_adder.sv
// Combinational IEEE half-precision adder, round-to-nearest-even,
// subnormal support, inf/NaN handling (NaN results are the canonical qNaN).
module float16_adder
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    fp16_fields_t fa, fb, fx, fy;
    logic         a_nan, b_nan, a_inf, b_inf, swap, sticky, rnd;
    logic [4:0]   ex_eff, ey_eff, dshift;
    logic [13:0]  mx, my, my_sh, m;
    logic [14:0]  sum;
    logic [5:0]   e;
    logic [11:0]  rm;

    always_comb begin
        fa     = fp16_fields_t'(a);
        fb     = fp16_fields_t'(b);
        a_nan  = (fa.exp == 5'h1f) && (fa.mant != 10'h0);
        b_nan  = (fb.exp == 5'h1f) && (fb.mant != 10'h0);
        a_inf  = (fa.exp == 5'h1f) && (fa.mant == 10'h0);
        b_inf  = (fb.exp == 5'h1f) && (fb.mant == 10'h0);
        // x is the operand with the larger magnitude
        swap   = {fb.exp, fb.mant} > {fa.exp, fa.mant};
        fx     = swap ? fb : fa;
        fy     = swap ? fa : fb;
        ex_eff = (fx.exp == 5'h0) ? 5'd1 : fx.exp;
        ey_eff = (fy.exp == 5'h0) ? 5'd1 : fy.exp;
        dshift = ex_eff - ey_eff;
        mx     = {(fx.exp != 5'h0), fx.mant, 3'b000};
        my     = {(fy.exp != 5'h0), fy.mant, 3'b000};
        sum    = '0;
        m      = '0;
        e      = {1'b0, ex_eff};

        // align with guard/round bits and a sticky LSB
        if (dshift >= 5'd14) begin
            sticky = |my;
            my_sh  = '0;
        end else begin
            sticky = |(my & ((14'd1 << dshift) - 14'd1));
            my_sh  = my >> dshift;
        end
        my_sh[0] = my_sh[0] | sticky;

        if (fx.sign == fy.sign) begin
            sum = {1'b0, mx} + {1'b0, my_sh};
            if (sum[14]) begin
                m    = sum[14:1];
                m[0] = m[0] | sum[0];
                e    = e + 6'd1;
            end else begin
                m = sum[13:0];
            end
        end else begin
            m = mx - my_sh;
            for (int i = 0; i < 13; i++) begin
                if (!m[13] && (e > 6'd1)) begin
                    m = m << 1;
                    e = e - 6'd1;
                end
            end
        end

        rnd = m[2] && (m[3] || m[1] || m[0]);
        rm  = {1'b0, m[13:3]} + 12'(rnd);
        if (rm[11]) begin
            rm = rm >> 1;
            e  = e + 6'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
            result = FP16_QNAN;
        end else if (a_inf) begin
            result = FP16_PINF | {fa.sign, 15'h0};
        end else if (b_inf) begin
            result = FP16_PINF | {fb.sign, 15'h0};
        end else if ((fx.sign != fy.sign) && (m == 14'h0)) begin
            result = FP16_ZERO;
        end else if (e >= 6'd31) begin
            result = FP16_PINF | {fx.sign, 15'h0};
        end else begin
            // subnormal results keep a zero exponent field
            result = {fx.sign, (rm[10] ? e[4:0] : 5'd0), rm[9:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    idx_c,
    output logic               found_c
);

    logic [ID_W-1:0] cand;
    logic            hit;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        hit     = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!hit && req[cand]) begin
                hit   = 1'b1;
                idx_c = cand;
            end
        end
        found_c = hit && en;
        if (found_c) begin
            grant_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Shares one fp16 adder among NUM_REQ requesters: round-robin grant,
// operand stage S1, result stage S2 tagged with the requester id.
module fp16_add_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned FLOAT_LEN = 16,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][FLOAT_LEN-1:0]  req_a,
    input  logic [NUM_REQ-1:0][FLOAT_LEN-1:0]  req_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FLOAT_LEN-1:0]               out_data,
    output logic [ID_W-1:0]                    out_id,
    output logic                               busy
);

    logic                 s1_valid_q, s1_valid_d;
    logic [FLOAT_LEN-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]      s1_id_q, s1_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [FLOAT_LEN-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic                 busy_q, busy_d;

    logic                 s1_free, s2_free, xfer;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic [FLOAT_LEN-1:0] sum;

    assign s2_free = !out_valid_q || out_ready;
    assign s1_free = !s1_valid_q || s2_free;

    // rst_n gate keeps req_ready low while reset is held
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .en      (s1_free && rst_n),
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant_c (gnt),
        .idx_c   (gnt_idx),
        .found_c (xfer)
    );

    float16_adder u_float16_adder (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (sum)
    );

    assign req_ready = gnt;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        if (s1_free) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_a_d   = req_a[gnt_idx];
                s1_b_d   = req_b[gnt_idx];
                s1_id_d  = gnt_idx;
                rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end

        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sum;
                out_id_d   = s1_id_q;
            end
        end

        busy_d = s1_valid_d || out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter with hand-computed fp16 results.
module tb_fp16_add_arbiter;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][15:0] req_a;
    logic [3:0][15:0] req_b;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic [1:0]      out_id;
    logic            busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fp16_add_arbiter #(
        .NUM_REQ   (4),
        .FLOAT_LEN (16),
        .ID_W      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] d, input logic [1:0] id);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_id"},    32'(out_id),    32'(id));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        step();

        // single request from requester 1: 1.0 + 2.0
        req_a[1] = 16'h3C00; req_b[1] = 16'h4000; req_valid = 4'b0010;
        #1 chk("t1_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        #1 chk("t1_s1_busy", 32'(busy), 32'h1);
        chk("t1_s1_ovalid", 32'(out_valid), 32'h0);
        chk("t1_idle_ready", 32'(req_ready), 32'h0);
        step();
        chk_out("t1_out", 16'h4200, 2'd1);
        chk("t1_out_busy", 32'(busy), 32'h1);
        step();
        chk("t1_pop_ovalid", 32'(out_valid), 32'h0);
        chk("t1_pop_busy", 32'(busy), 32'h0);

        // requester 3 alone (1+1) moves the pointer back to 0
        req_a[3] = 16'h3C00; req_b[3] = 16'h3C00; req_valid = 4'b1000;
        #1 chk("t2_pre_ready", 32'(req_ready), 32'h8);
        step();
        for (int k = 0; k < 4; k++) begin
            req_a[k] = 16'h3E00;
            req_b[k] = 16'hBE00;
        end
        req_valid = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant", 32'(req_ready), 32'(1) << (i % 4));
            if (i == 0)      chk("t2_ovalid0", 32'(out_valid), 32'h0);
            else if (i == 1) chk_out("t2_out_pre", 16'h4000, 2'd3);
            else             chk_out("t2_out", 16'h0000, 2'(i - 2));
            step();
        end
        req_valid = 4'h0;
        #1 chk_out("t2_out3", 16'h0000, 2'd3);
        step();
        chk_out("t2_out0", 16'h0000, 2'd0);
        step();
        chk("t2_drain_ovalid", 32'(out_valid), 32'h0);
        chk("t2_drain_busy", 32'(busy), 32'h0);

        // requester 2 alone (2 + -3) leaves the pointer at 3, then wrap test
        req_a[2] = 16'h4000; req_b[2] = 16'hC200; req_valid = 4'b0100;
        #1 chk("t3_pre_ready", 32'(req_ready), 32'h4);
        step();
        req_a[0] = 16'h3C00; req_b[0] = 16'h3800;
        req_a[2] = 16'hC000; req_b[2] = 16'hC000;
        req_valid = 4'b0101;
        #1 chk("t3_wrap_grant", 32'(req_ready), 32'h1);
        chk("t3_ovalid", 32'(out_valid), 32'h0);
        step();
        chk_out("t3_out_sub", 16'hBC00, 2'd2);
        chk("t3_second_grant", 32'(req_ready), 32'h4);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        #1 chk_out("t3_out_half", 16'h3E00, 2'd0);
        step();
        chk_out("t3_out_neg4", 16'hC400, 2'd2);
        step();
        chk("t3_drain_ovalid", 32'(out_valid), 32'h0);

        // back-pressure: S2 held, skid of one into S1, then release
        out_ready = 1'b0;
        req_a[0] = 16'h4000; req_b[0] = 16'h4000; req_valid = 4'b0001;
        #1 chk("t4_first_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        #1 chk("t4_gap_ready", 32'(req_ready), 32'h0);
        chk("t4_gap_ovalid", 32'(out_valid), 32'h0);
        step();
        chk_out("t4_full", 16'h4400, 2'd0);
        req_valid = 4'b0001;
        #1 chk("t4_skid_ready", 32'(req_ready), 32'h1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_ready", 32'(req_ready), 32'h0);
            chk_out("t4_stall_out", 16'h4400, 2'd0);
            chk("t4_stall_busy", 32'(busy), 32'h1);
            step();
        end
        out_ready = 1'b1;
        req_valid = 4'b0000;
        #1 chk_out("t4_rel_first", 16'h4400, 2'd0);
        step();
        chk_out("t4_rel_second", 16'h4400, 2'd0);
        step();
        chk("t4_rel_empty", 32'(out_valid), 32'h0);
        chk("t4_rel_busy", 32'(busy), 32'h0);

        // special values through requester 1
        req_a[1] = 16'h7C00; req_b[1] = 16'h3C00; req_valid = 4'b0010;
        #1 chk("t5_inf_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        step();
        chk_out("t5_inf", 16'h7C00, 2'd1);
        req_a[1] = 16'h7C00; req_b[1] = 16'hFC00; req_valid = 4'b0010;
        #1 chk("t5_nan_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        step();
        chk("t5_nan_valid", 32'(out_valid), 32'h1);
        chk("t5_nan_bits", 32'((out_data[14:10] == 5'h1f) && (out_data[9:0] != 10'h0)), 32'h1);
        chk("t5_nan_id", 32'(out_id), 32'h1);
        step();
        chk("t5_drain_ovalid", 32'(out_valid), 32'h0);

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        req_a[1] = 16'h3C00; req_b[1] = 16'h3C00;
        req_a[2] = 16'h3C00; req_b[2] = 16'h3C00;
        req_valid = 4'b0110;
        #1 chk("t6_grant2", 32'(req_ready), 32'h4);
        step();
        chk("t6_grant1", 32'(req_ready), 32'h2);
        step();
        chk("t6_full_busy", 32'(busy), 32'h1);
        chk("t6_full_ovalid", 32'(out_valid), 32'h1);
        chk("t6_full_ready", 32'(req_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_ovalid", 32'(out_valid), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_ready", 32'(req_ready), 32'h0);
        chk("t6_rst_data", 32'(out_data), 32'h0);
        chk("t6_rst_id", 32'(out_id), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("t6_post_rst_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        #1 chk("t6_post_s1_ovalid", 32'(out_valid), 32'h0);
        step();
        chk_out("t6_post_out", 16'h4000, 2'd1);
        step();
        chk("t6_end_ovalid", 32'(out_valid), 32'h0);
        chk("t6_end_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
